// File: rtl/fpu_issue_ctrl.sv
// Issue controller for a fixed-latency, non-stallable FPU: credit-gated op issue,
// per-stage result tracking and an in-order first-word fall-through result FIFO.
module fpu_issue_ctrl #(
  parameter int FPU_LAT = 6,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic [1:0]       req_rmode,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_sel,
  output logic [1:0]       fpu_round_mode,
  output logic             fpu_start,
  input  logic [31:0]      fpu_y,
  input  logic             fpu_error,
  input  logic             fpu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic             rsp_error,
  output logic             rsp_overflow,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             flush,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] MAX_OUT = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  typedef struct packed {
    logic [31:0]      y;
    logic             error;
    logic             overflow;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [CNT_W-1:0] inflight_cnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   outstanding;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  rsp_t             mem [DEPTH];
  rsp_t             head;
  logic [FPU_LAT:0] trk_valid;
  logic [TAG_W-1:0] trk_tag [FPU_LAT+1];

  // Both handshakes transfer on a rising edge where valid & ready are high; req_ready
  // depends only on registered counts plus reset/flush, never on req_valid or rsp_ready.
  assign outstanding = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign req_ready   = !reset && !flush && (outstanding < MAX_OUT);
  assign accept      = req_valid && req_ready;
  assign push        = trk_valid[FPU_LAT] && !flush;
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop         = rsp_ready && !fifo_empty && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpu_a          <= '0;
      fpu_b          <= '0;
      fpu_sel        <= '0;
      fpu_round_mode <= '0;
      fpu_start      <= 1'b0;
    end else begin
      fpu_start <= accept;
      if (accept) begin
        fpu_a          <= req_a;
        fpu_b          <= req_b;
        fpu_sel        <= req_op;
        fpu_round_mode <= req_rmode;
      end
    end
  end

  // The last tracking stage lines up with the cycle the FPU presents this op's result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_valid <= '0;
    end else if (flush) begin
      trk_valid <= '0;
    end else begin
      trk_valid <= {trk_valid[FPU_LAT-1:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    trk_tag[0] <= req_tag;
    for (int i = 1; i <= FPU_LAT; i++) begin
      trk_tag[i] <= trk_tag[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else if (flush) begin
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      inflight_cnt <= inflight_cnt + CNT_W'(accept) - CNT_W'(push);
      fifo_cnt     <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        assert (!fifo_full);
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PTR_W-1:0]] <= '{y: fpu_y, error: fpu_error, overflow: fpu_overflow,
                                  tag: trk_tag[FPU_LAT]};
    end
  end

  // Head fields read as zero while empty so stale entries never leak out.
  assign head         = mem[rd_ptr[PTR_W-1:0]];
  assign rsp_valid    = !fifo_empty;
  assign rsp_y        = rsp_valid ? head.y : '0;
  assign rsp_error    = rsp_valid && head.error;
  assign rsp_overflow = rsp_valid && head.overflow;
  assign rsp_tag      = rsp_valid ? head.tag : '0;
  assign busy         = (inflight_cnt != '0) || (fifo_cnt != '0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: behavioural fixed-latency FPU, queued request driver,
// scoreboard of expected results and a decoupled response monitor.
module tb_fpu_issue_ctrl;
  localparam int FPU_LAT = 6;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [1:0]       req_op;
  logic [1:0]       req_rmode;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_sel;
  logic [1:0]       fpu_round_mode;
  logic             fpu_start;
  logic [31:0]      fpu_y;
  logic             fpu_error;
  logic             fpu_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_y;
  logic             rsp_error;
  logic             rsp_overflow;
  logic [TAG_W-1:0] rsp_tag;
  logic             flush;
  logic             busy;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       op;
    logic [1:0]       rmode;
    logic [TAG_W-1:0] tag;
    logic [31:0]      y;
    logic             err;
    logic             ovf;
  } req_t;

  req_t        req_q[$];
  logic [37:0] exp_q[$];
  logic [37:0] mon_exp;
  logic [34:0] fpu_pipe [FPU_LAT+1];
  logic        drv_hs;
  logic        chk_outst;
  int          rsp_mode;
  int          n_checks;
  int          n_errors;
  int          n_acc;
  int          n_pop;
  int          n_drop;
  int          base;
  int          pbase;

  fpu_issue_ctrl #(.FPU_LAT(FPU_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_rmode(req_rmode), .req_tag(req_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_round_mode(fpu_round_mode),
    .fpu_start(fpu_start), .fpu_y(fpu_y), .fpu_error(fpu_error), .fpu_overflow(fpu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_error(rsp_error),
    .rsp_overflow(rsp_overflow), .rsp_tag(rsp_tag), .flush(flush), .busy(busy)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // FPU behaviour: hand-computed results for the directed operands, a scrambling
  // function otherwise so every op has a distinctive result and flag pattern.
  function automatic logic [33:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] sel);
    if (sel == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 2'b00};
    if (sel == 2'd2 && a == 32'h40000000 && b == 32'h40400000) return {32'h40C00000, 2'b00};
    if (sel == 2'd3 && a == 32'h3F800000 && b == 32'h00000000) return {32'h7F800000, 2'b10};
    return {a ^ {b[15:0], b[31:16]} ^ {30'd0, sel}, a[3] ^ b[5], a[7] & sel[0]};
  endfunction

  // Operands are sampled mid-cycle while fpu_start is high; the result is presented
  // FPU_LAT cycles later and garbage is driven in every other cycle.
  initial begin
    fpu_y = '0;
    fpu_error = 1'b0;
    fpu_overflow = 1'b0;
    for (int i = 0; i <= FPU_LAT; i++) fpu_pipe[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = FPU_LAT; i > 0; i--) fpu_pipe[i] = fpu_pipe[i-1];
      fpu_pipe[0] = {fpu_start, fpu_fn(fpu_a, fpu_b, fpu_sel)};
      if (fpu_pipe[FPU_LAT][34]) {fpu_y, fpu_error, fpu_overflow} = fpu_pipe[FPU_LAT][33:0];
      else {fpu_y, fpu_error, fpu_overflow} = {32'hDEADBEEF, 2'b11};
    end
  end

  // Driver tasks
  task automatic add_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic [1:0] rm, input logic [TAG_W-1:0] tag,
                         input logic [31:0] y, input logic err, input logic ovf);
    req_q.push_back('{a: a, b: b, op: op, rmode: rm, tag: tag, y: y, err: err, ovf: ovf});
  endtask

  task automatic add_model_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                               input logic [1:0] rm, input logic [TAG_W-1:0] tag);
    logic [33:0] r;
    r = fpu_fn(a, b, op);
    add_req(a, b, op, rm, tag, r[33:2], r[1], r[0]);
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    for (int i = 0; i < budget && n_acc < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk(name, 64'(n_acc >= target), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (req_q.size() == 0 && exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 64'(done), 1);
  endtask

  initial begin
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    req_rmode = '0;
    req_tag = '0;
    forever begin
      @(negedge clk);
      drv_hs = req_valid && req_ready;
      if (drv_hs) begin
        exp_q.push_back({req_q[0].y, req_q[0].err, req_q[0].ovf, req_q[0].tag});
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (drv_hs) void'(req_q.pop_front());
      if (req_q.size() > 0) begin
        req_valid = 1'b1;
        req_a     = req_q[0].a;
        req_b     = req_q[0].b;
        req_op    = req_q[0].op;
        req_rmode = req_q[0].rmode;
        req_tag   = req_q[0].tag;
      end else begin
        req_valid = 1'b0;
      end
    end
  end

  // rsp_mode: 0 hold low, 1 hold high, 2 toggle every cycle
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = ~rsp_ready;
      endcase
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset || flush) begin
        exp_q.delete();
        n_drop = n_acc - n_pop;
      end else begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 0);
        end else if (rsp_valid && rsp_ready) begin
          mon_exp = exp_q.pop_front();
          chk("rsp_data", 64'({rsp_y, rsp_error, rsp_overflow, rsp_tag}), 64'(mon_exp));
          n_pop++;
        end
        if (chk_outst) chk("outstanding_le_depth", 64'((n_acc - n_pop - n_drop) <= DEPTH), 1);
      end
    end
  end

  // Directed sequence
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    rsp_mode = 1;
    chk_outst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 0);
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_fpu_start", 64'(fpu_start), 0);
    chk("reset_fpu_a", 64'(fpu_a), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", 64'(req_ready), 1);

    // 1: single add, issue strobe and result latency
    add_req(32'h3F800000, 32'h40000000, 2'd0, 2'd1, 4'd3, 32'h40400000, 1'b0, 1'b0);
    wait_acc("t1_accept", n_acc + 1, 20);
    chk("t1_start_before_accept", 64'(fpu_start), 0);
    @(negedge clk);
    chk("t1_start", 64'(fpu_start), 1);
    chk("t1_fpu_a", 64'(fpu_a), 64'h3F800000);
    chk("t1_fpu_b", 64'(fpu_b), 64'h40000000);
    chk("t1_fpu_sel", 64'(fpu_sel), 0);
    chk("t1_fpu_rmode", 64'(fpu_round_mode), 1);
    chk("t1_busy", 64'(busy), 1);
    @(negedge clk);
    chk("t1_start_once", 64'(fpu_start), 0);
    chk("t1_fpu_a_hold", 64'(fpu_a), 64'h3F800000);
    repeat (5) @(negedge clk);
    chk("t1_rsp_not_early", 64'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 1);
    chk("t1_rsp_y", 64'(rsp_y), 64'h40400000);
    chk("t1_rsp_tag", 64'(rsp_tag), 3);
    wait_idle("t1_drain", 30);

    // 2: back-to-back mul and div-by-zero, flags carried through
    add_req(32'h40000000, 32'h40400000, 2'd2, 2'd0, 4'd5, 32'h40C00000, 1'b0, 1'b0);
    add_req(32'h3F800000, 32'h00000000, 2'd3, 2'd2, 4'hA, 32'h7F800000, 1'b1, 1'b0);
    wait_idle("t2_drain", 40);

    // 3: consumer stalled, credits run out at DEPTH
    rsp_mode = 0;
    repeat (2) @(negedge clk);
    base = n_acc;
    pbase = n_pop;
    for (int i = 0; i < 6; i++)
      add_model_req(32'h41000000 + 32'(i), 32'h3F000000 | 32'(i << 4), 2'(i), 2'(i), 4'(i + 8));
    repeat (20) @(negedge clk);
    chk("t3_accepted", 64'(n_acc - base), 4);
    chk("t3_req_ready_low", 64'(req_ready), 0);
    chk("t3_busy", 64'(busy), 1);
    chk("t3_rsp_valid_held", 64'(rsp_valid), 1);
    rsp_mode = 1;
    wait_idle("t3_drain", 80);
    chk("t3_all_returned", 64'(n_pop - pbase), 6);

    // 4: flush with three ops in flight
    base = n_acc;
    for (int i = 0; i < 3; i++)
      add_model_req(32'h42000000 ^ 32'(i * 33), 32'h3E000000 + 32'(i), 2'(i + 1), 2'd0, 4'(i + 1));
    wait_acc("t4_accept", base + 3, 20);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("t4_ready_blocked", 64'(req_ready), 0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("t4_busy_cleared", 64'(busy), 0);
    chk("t4_rsp_valid", 64'(rsp_valid), 0);
    chk("t4_req_ready_back", 64'(req_ready), 1);
    repeat (12) @(negedge clk);
    pbase = n_pop;
    add_model_req(32'h40800000, 32'h40A00000, 2'd2, 2'd3, 4'd7);
    wait_idle("t4_new_op", 30);
    chk("t4_new_op_returned", 64'(n_pop - pbase), 1);

    // 5: reset with one result queued and two in flight
    rsp_mode = 0;
    repeat (2) @(negedge clk);
    base = n_acc;
    add_model_req(32'h12345678, 32'h9ABCDEF0, 2'd1, 2'd1, 4'd2);
    wait_acc("t5_accept_first", base + 1, 20);
    repeat (3) @(negedge clk);
    add_model_req(32'h0F0F0F0F, 32'h55AA55AA, 2'd2, 2'd2, 4'd4);
    add_model_req(32'hC0000000, 32'h3F800000, 2'd3, 2'd3, 4'd6);
    wait_acc("t5_accept_rest", base + 3, 20);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    chk("t5_queued", 64'(rsp_valid), 1);
    chk("t5_busy", 64'(busy), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t5_fpu_a", 64'(fpu_a), 0);
    chk("t5_fpu_b", 64'(fpu_b), 0);
    chk("t5_fpu_ctrl", 64'({fpu_sel, fpu_round_mode, fpu_start}), 0);
    chk("t5_rsp", 64'({rsp_valid, rsp_y, rsp_error, rsp_overflow, rsp_tag}), 0);
    chk("t5_busy_ready", 64'({busy, req_ready}), 0);
    rsp_mode = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t5_req_ready_after", 64'(req_ready), 1);
    repeat (15) @(negedge clk);
    chk("t5_no_stale_rsp", 64'(rsp_valid), 0);
    chk("t5_idle", 64'(busy), 0);

    // 6: stream of 20 with a toggling consumer
    pbase = n_pop;
    chk_outst = 1'b1;
    rsp_mode = 2;
    for (int i = 0; i < 20; i++)
      add_model_req(32'h3F800000 + 32'(i * 4099), 32'h40000000 ^ 32'(i * 77), 2'(i), 2'(i + 1),
                    4'(i));
    wait_idle("t6_drain", 600);
    chk("t6_count", 64'(n_pop - pbase), 20);
    chk_outst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
